// File: rtl/ifetch_pkg.sv
// ifetch_pkg: shared types and defaults for the instruction-fetch sequencer
package ifetch_pkg;
  localparam int MEM_LAT = 3;
  localparam int IMSZLOG2 = 14;
  localparam int INSTRW = 32;
  typedef enum logic [1:0] {IDLE, FETCH, STOP, HALTED} fetch_state_e;
  typedef struct packed {
    logic valid;
    logic kill;
    logic [IMSZLOG2-1:0] pc;
  } shadow_t;
endpackage

// File: rtl/ifetch_if.sv
// ifetch_if: ROM read bus and decode-side valid/ready handshake
interface ifetch_if #(parameter int IMSZLOG2 = 14, parameter int INSTRW = 32);
  logic [IMSZLOG2-1:0] mem_addr;
  logic mem_ren;
  logic mem_halt;
  logic [INSTRW-1:0] mem_im;
  logic mem_ins_valid;
  logic [INSTRW-1:0] ins_o;
  logic [IMSZLOG2-1:0] ins_pc_o;
  logic ins_valid_o;
  logic ins_ready_i;
  modport master (
    output mem_addr, mem_ren, mem_halt, ins_o, ins_pc_o, ins_valid_o,
    input mem_im, mem_ins_valid, ins_ready_i
  );
  modport slave (
    input mem_addr, mem_ren, mem_halt, ins_o, ins_pc_o, ins_valid_o,
    output mem_im, mem_ins_valid, ins_ready_i
  );
endinterface

// File: rtl/ifetch_fifo.sv
// ifetch_fifo: synchronous FIFO with registered storage, flush and occupancy count
module ifetch_fifo #(
  parameter int W = 46,
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic flush,
  input  logic push,
  input  logic [W-1:0] din,
  input  logic pop,
  output logic [W-1:0] dout,
  output logic [$clog2(DEPTH):0] count,
  output logic empty,
  output logic full
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] rd_q, wr_q;
  logic [CW-1:0] count_q;
  logic do_push, do_pop;
  assign count = count_q;
  assign empty = count_q == '0;
  assign full = count_q == CW'(DEPTH);
  assign do_pop = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign dout = mem_q[rd_q];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= din;
        wr_q <= wr_q + AW'(1);
      end
      if (do_pop) rd_q <= rd_q + AW'(1);
      count_q <= count_q + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/ifetch_ctrl.sv
// ifetch_ctrl: PC sequencer issuing credit-limited ROM reads into a decode FIFO
module ifetch_ctrl #(
  parameter int IMSZLOG2 = ifetch_pkg::IMSZLOG2,
  parameter int INSTRW = ifetch_pkg::INSTRW,
  parameter int FIFO_DEPTH = 4,
  parameter int MEM_LAT = ifetch_pkg::MEM_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start,
  input  logic [IMSZLOG2-1:0] start_pc,
  input  logic [IMSZLOG2-1:0] end_pc,
  input  logic halt,
  input  logic redir_valid,
  input  logic [IMSZLOG2-1:0] redir_pc,
  ifetch_if.master bus,
  output logic busy,
  output logic done
);
  import ifetch_pkg::*;
  fetch_state_e state_q, state_d;
  logic [IMSZLOG2-1:0] pc_q, pc_d, endr_q, endr_d, addr_q;
  logic ren_q, mhalt_q, issue, kill, clr, push, pop, empty, full;
  logic [$clog2(FIFO_DEPTH):0] count;
  logic [INSTRW+IMSZLOG2-1:0] head;
  shadow_t [MEM_LAT-1:0] sh_q;
  int inflight;
  assign bus.mem_addr = addr_q;
  assign bus.mem_ren = ren_q;
  assign bus.mem_halt = mhalt_q;
  assign bus.ins_valid_o = ~empty;
  assign {bus.ins_o, bus.ins_pc_o} = head;
  assign busy = state_q inside {FETCH, STOP};
  assign pop = bus.ins_valid_o & bus.ins_ready_i;
  assign push = bus.mem_ins_valid & sh_q[MEM_LAT-1].valid & ~sh_q[MEM_LAT-1].kill;
  // the read sitting in mem_ren holds a credit too, one cycle before it enters the shadow pipe
  always_comb begin
    inflight = int'(ren_q);
    for (int i = 0; i < MEM_LAT; i++) inflight = inflight + int'(sh_q[i].valid & ~sh_q[i].kill);
  end
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    endr_d = endr_q;
    issue = 1'b0;
    kill = 1'b0;
    clr = 1'b0;
    done = 1'b0;
    if (halt) begin
      state_d = HALTED;
      clr = 1'b1;
    end else if (state_q inside {IDLE, HALTED}) begin
      if (start) begin
        state_d = FETCH;
        pc_d = start_pc;
        endr_d = end_pc;
        clr = 1'b1;
      end
    end else if (redir_valid) begin
      state_d = FETCH;
      pc_d = redir_pc;
      kill = 1'b1;
    end else if (state_q == FETCH) begin
      issue = (int'(count) - int'(pop) + inflight) < FIFO_DEPTH;
      pc_d = issue ? pc_q + IMSZLOG2'(1) : pc_q;
      state_d = (issue && pc_q == endr_q) ? STOP : FETCH;
    end else if (inflight == 0 && empty) begin
      done = 1'b1;
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= '0;
      endr_q <= '0;
      addr_q <= '0;
      ren_q <= 1'b0;
      mhalt_q <= 1'b0;
      sh_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      endr_q <= endr_d;
      ren_q <= issue;
      mhalt_q <= halt;
      if (issue) addr_q <= pc_q;
      sh_q[0] <= clr ? '0 : shadow_t'{ren_q, kill, addr_q};
      for (int i = 1; i < MEM_LAT; i++)
        sh_q[i] <= clr ? '0 : shadow_t'{sh_q[i-1].valid, sh_q[i-1].kill | kill, sh_q[i-1].pc};
    end
  // the cycle after a halt the ROM has not yet seen mem_halt, so its last stage may still be valid
  always_ff @(posedge clk)
    if (rst_n && !mhalt_q) begin
      assert (bus.mem_ins_valid == sh_q[MEM_LAT-1].valid);
      assert (!(push && full && !pop));
    end
  ifetch_fifo #(.W(INSTRW + IMSZLOG2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .flush(clr | kill),
    .push(push),
    .din({bus.mem_im, sh_q[MEM_LAT-1].pc}),
    .pop(pop),
    .dout(head),
    .count(count),
    .empty(empty),
    .full(full)
  );
endmodule

// File: tb/tb_ifetch_ctrl.sv
// tb_ifetch_ctrl: scoreboard bench with a 3-stage ROM model for ifetch_ctrl
module tb_ifetch_ctrl;
  import ifetch_pkg::*;
  localparam int AW = 14;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic halt = 1'b0;
  logic redir_valid = 1'b0;
  logic [AW-1:0] start_pc = '0;
  logic [AW-1:0] end_pc = '0;
  logic [AW-1:0] redir_pc = '0;
  logic busy, done;
  int checks = 0;
  int errors = 0;
  int dones = 0;
  int rens = 0;
  int cyc_n = 0;
  int last_pop = 0;
  int done_at = 0;
  logic [AW-1:0] exp_q [$];
  logic [AW-1:0] ep;
  logic [MEM_LAT-1:0] rv;
  logic [AW-1:0] ra [MEM_LAT];

  ifetch_if #(.IMSZLOG2(AW), .INSTRW(DW)) bus ();

  ifetch_ctrl #(.IMSZLOG2(AW), .INSTRW(DW), .FIFO_DEPTH(DEPTH), .MEM_LAT(MEM_LAT)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .start_pc(start_pc),
    .end_pc(end_pc),
    .halt(halt),
    .redir_valid(redir_valid),
    .redir_pc(redir_pc),
    .bus(bus),
    .busy(busy),
    .done(done)
  );

  always #5 clk = ~clk;

  function automatic logic [DW-1:0] rom_data(input logic [AW-1:0] a);
    return 32'hC0DE_0000 ^ {18'h0, a};
  endfunction

  always @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      rv <= '0;
      for (int i = 0; i < MEM_LAT; i++) ra[i] <= '0;
    end else if (bus.mem_halt) begin
      rv <= '0;
    end else begin
      rv <= {rv[MEM_LAT-2:0], bus.mem_ren};
      ra[0] <= bus.mem_addr;
      for (int i = 1; i < MEM_LAT; i++) ra[i] <= ra[i-1];
    end
  assign bus.mem_ins_valid = rv[MEM_LAT-1];
  assign bus.mem_im = rom_data(ra[MEM_LAT-1]);

  always @(posedge clk) cyc_n++;

  always @(negedge clk)
    if (rst_n) begin
      if (bus.mem_ren) rens++;
      if (done) begin
        dones++;
        done_at = cyc_n;
      end
      if (bus.ins_valid_o && bus.ins_ready_i) begin
        checks++;
        last_pop = cyc_n;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got pc=%h ins=%h, required no output", bus.ins_pc_o, bus.ins_o);
        end else begin
          ep = exp_q.pop_front();
          if (bus.ins_pc_o !== ep || bus.ins_o !== rom_data(ep)) begin
            errors++;
            $display("FAIL pop got pc=%h ins=%h, required pc=%h ins=%h", bus.ins_pc_o, bus.ins_o, ep, rom_data(ep));
          end
        end
      end
    end

  task automatic cyc(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic start_prog(input logic [AW-1:0] s, input logic [AW-1:0] e);
    start_pc = s;
    end_pc = e;
    start = 1'b1;
    cyc();
    start = 1'b0;
  endtask

  task automatic expect_range(input logic [AW-1:0] s, input int n);
    logic [AW-1:0] p = s;
    for (int i = 0; i < n; i++) begin
      exp_q.push_back(p);
      p = p + AW'(1);
    end
  endtask

  task automatic wait_done(input string name);
    int d0 = dones;
    for (int i = 0; i < 200 && dones == d0; i++) @(negedge clk);
    checks++;
    if (dones != d0 + 1) begin
      errors++;
      $display("FAIL %s_done got %0d pulses, required 1", name, dones - d0);
    end
    cyc(3);
    checks++;
    if (busy !== 1'b0 || dones != d0 + 1) begin
      errors++;
      $display("FAIL %s_idle got busy=%b pulses=%0d, required busy=0 pulses=1", name, busy, dones - d0);
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain got %0d missing, required 0", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset;
    bus.ins_ready_i = 1'b1;
    cyc(2);
    checks++;
    if ({bus.mem_addr, bus.mem_ren, bus.mem_halt, bus.ins_valid_o, bus.ins_o, bus.ins_pc_o, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset got addr=%h ren=%b mhalt=%b v=%b ins=%h pc=%h busy=%b done=%b, required all 0",
               bus.mem_addr, bus.mem_ren, bus.mem_halt, bus.ins_valid_o, bus.ins_o, bus.ins_pc_o, busy, done);
    end
    rst_n = 1'b1;
    cyc(2);
    checks++;
    if (busy !== 1'b0 || bus.mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL reset_idle got busy=%b ren=%b, required 0 0", busy, bus.mem_ren);
    end
  endtask

  task automatic test_basic;
    bus.ins_ready_i = 1'b1;
    expect_range(AW'('h10), 8);
    start_prog(AW'('h10), AW'('h17));
    @(negedge clk);
    checks++;
    if (bus.mem_ren !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL start_cycle got ren=%b busy=%b, required 0 1", bus.mem_ren, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_ren !== 1'b1 || bus.mem_addr !== AW'('h10)) begin
      errors++;
      $display("FAIL first_ren got ren=%b addr=%h, required 1 0010", bus.mem_ren, bus.mem_addr);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (bus.mem_ins_valid !== 1'b1 || bus.ins_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL rom_latency got mvalid=%b ivalid=%b, required 1 0", bus.mem_ins_valid, bus.ins_valid_o);
    end
    @(negedge clk);
    checks++;
    if (bus.ins_valid_o !== 1'b1 || bus.ins_pc_o !== AW'('h10)) begin
      errors++;
      $display("FAIL ins_latency got v=%b pc=%h, required 1 0010", bus.ins_valid_o, bus.ins_pc_o);
    end
    wait_done("basic");
    checks++;
    if (done_at != last_pop + 1) begin
      errors++;
      $display("FAIL done_timing got cycle %0d, required %0d", done_at, last_pop + 1);
    end
  endtask

  task automatic test_backpressure;
    int r0;
    bus.ins_ready_i = 1'b0;
    r0 = rens;
    expect_range(AW'('h10), 8);
    start_prog(AW'('h10), AW'('h17));
    cyc(10);
    checks++;
    if (rens - r0 != DEPTH) begin
      errors++;
      $display("FAIL credit_stop got %0d issues, required %0d", rens - r0, DEPTH);
    end
    checks++;
    if (bus.ins_valid_o !== 1'b1 || bus.ins_pc_o !== AW'('h10)) begin
      errors++;
      $display("FAIL held_head got v=%b pc=%h, required 1 0010", bus.ins_valid_o, bus.ins_pc_o);
    end
    bus.ins_ready_i = 1'b1;
    wait_done("backpressure");
  endtask

  task automatic test_redirect;
    bus.ins_ready_i = 1'b0;
    start_prog(AW'('h10), AW'('h17));
    cyc(1);
    redir_valid = 1'b1;
    redir_pc = AW'('h40);
    cyc(1);
    redir_valid = 1'b0;
    cyc(10);
    checks++;
    if (bus.ins_valid_o !== 1'b1 || bus.ins_pc_o !== AW'('h40)) begin
      errors++;
      $display("FAIL redir_head got v=%b pc=%h, required 1 0040", bus.ins_valid_o, bus.ins_pc_o);
    end
    expect_range(AW'('h40), 4);
    bus.ins_ready_i = 1'b1;
    cyc(4);
    bus.ins_ready_i = 1'b0;
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    checks++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL redir_drain got missing=%0d busy=%b, required 0 0", exp_q.size(), busy);
      exp_q.delete();
    end
  endtask

  task automatic test_halt;
    bus.ins_ready_i = 1'b0;
    start_prog(AW'('h10), AW'('h17));
    cyc(5);
    checks++;
    if (bus.ins_valid_o !== 1'b1) begin
      errors++;
      $display("FAIL pre_halt got v=%b, required 1", bus.ins_valid_o);
    end
    halt = 1'b1;
    cyc(1);
    halt = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.mem_halt !== 1'b1 || bus.ins_valid_o !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL halt_state got mhalt=%b v=%b busy=%b, required 1 0 0", bus.mem_halt, bus.ins_valid_o, busy);
    end
    @(negedge clk);
    checks++;
    if (bus.mem_halt !== 1'b0) begin
      errors++;
      $display("FAIL halt_pulse got mhalt=%b, required 0", bus.mem_halt);
    end
    cyc(1);
    bus.ins_ready_i = 1'b1;
    cyc(8);
    checks++;
    if (bus.ins_valid_o !== 1'b0 || bus.mem_ren !== 1'b0) begin
      errors++;
      $display("FAIL halt_quiet got v=%b ren=%b, required 0 0", bus.ins_valid_o, bus.mem_ren);
    end
    expect_range(AW'(0), 4);
    start_prog(AW'(0), AW'(3));
    wait_done("restart");
  endtask

  task automatic test_wrap;
    bus.ins_ready_i = 1'b1;
    expect_range(AW'('h3FFE), 4);
    start_prog(AW'('h3FFE), AW'(1));
    wait_done("wrap");
  endtask

  task automatic test_reset_mid;
    bus.ins_ready_i = 1'b0;
    start_prog(AW'('h10), AW'('h17));
    cyc(3);
    rst_n = 1'b0;
    #2;
    checks++;
    if ({bus.mem_addr, bus.mem_ren, bus.mem_halt, bus.ins_valid_o, bus.ins_o, bus.ins_pc_o, busy, done} !== '0) begin
      errors++;
      $display("FAIL reset_mid got addr=%h ren=%b mhalt=%b v=%b ins=%h pc=%h busy=%b done=%b, required all 0",
               bus.mem_addr, bus.mem_ren, bus.mem_halt, bus.ins_valid_o, bus.ins_o, bus.ins_pc_o, busy, done);
    end
    cyc(1);
    rst_n = 1'b1;
    bus.ins_ready_i = 1'b1;
    cyc(10);
    checks++;
    if (busy !== 1'b0 || bus.ins_valid_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_quiet got busy=%b v=%b, required 0 0", busy, bus.ins_valid_o);
    end
  endtask

  initial begin
    bus.ins_ready_i = 1'b0;
    test_reset();
    test_basic();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
